// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
// Package : scope_pkg
// Shared widths and enumerations for the oscilloscope acquisition path.
// Rev     : 1.0
// ============================================================================
package scope_pkg;

  localparam int SAMPLE_W = 10;
  localparam int SCREEN_W = 640;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    NORMAL = 2'd1,
    SINGLE = 2'd2
  } trig_mode_t;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    WAIT = 3'd1,
    POST = 3'd2,
    SWAP = 3'd3,
    HOLD = 3'd4
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
// Module : capture_ram
// Ping-pong frame store: one write port, one registered read port, bank = MSB.
// Rev    : 1.0
// ============================================================================
module capture_ram
  import scope_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = SCREEN_W
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic                     i_wr_bank,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_bank,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [2][DEPTH];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
    end
    r_q <= r_mem[i_rd_bank][i_rd_addr];
  end

  assign o_rd_data = r_q;

endmodule
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module : trigger_capture
// Level-crossing trigger capture into a ping-pong RAM; display reads front bank.
// Rev    : 1.0
// ============================================================================
module trigger_capture
  import scope_pkg::*;
#(
  parameter int WIDTH        = SAMPLE_W,
  parameter int DEPTH        = SCREEN_W,
  parameter int PRE          = 320,
  parameter int HYST         = 4,
  parameter int AUTO_TIMEOUT = 2048
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_sample_valid,
  input  logic [WIDTH-1:0]         i_sample,
  input  logic [WIDTH-1:0]         i_level,
  input  logic                     i_slope,
  input  logic [1:0]               i_mode,
  input  logic                     i_rearm,
  input  logic [$clog2(DEPTH)-1:0] i_rd_x,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [2:0]               o_state,
  output logic                     o_triggered,
  output logic                     o_frame_done
);

  localparam int C_IDX_W  = $clog2(DEPTH);
  localparam int C_TO_W   = $clog2(AUTO_TIMEOUT + 1);
  localparam int C_POST_N = DEPTH - PRE - 1;

  localparam logic [C_IDX_W-1:0] C_LAST_ADDR = C_IDX_W'(DEPTH - 1);
  localparam logic [C_IDX_W-1:0] C_PRE_LAST  = C_IDX_W'(PRE - 1);
  localparam logic [C_IDX_W-1:0] C_POST_LAST = C_IDX_W'((C_POST_N > 0) ? (C_POST_N - 1) : 0);
  localparam logic [C_IDX_W-1:0] C_PRE       = C_IDX_W'(PRE);
  localparam logic [C_IDX_W-1:0] C_BACK_OFS  = C_IDX_W'(DEPTH - PRE);
  localparam logic [C_IDX_W:0]   C_DEPTH_X   = (C_IDX_W + 1)'(DEPTH);
  localparam logic [C_TO_W-1:0]  C_TO_LAST   = C_TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [WIDTH:0]     C_HYST      = (WIDTH + 1)'(HYST);
  localparam logic [WIDTH:0]     C_MAX       = {1'b0, {WIDTH{1'b1}}};

  cap_state_t         r_state;
  logic [C_IDX_W-1:0] r_wr_ptr;
  logic [C_IDX_W-1:0] r_cnt;
  logic [C_IDX_W-1:0] r_start;
  logic [C_IDX_W-1:0] r_trig_addr;
  logic [C_TO_W-1:0]  r_timeout;
  logic               r_front;
  logic               r_armed;
  logic               r_trig_flag;
  logic               r_triggered;
  logic               r_frame_done;
  logic               r_rd_zero;

  logic [WIDTH:0]     w_level_x;
  logic [WIDTH:0]     w_hi_sum;
  logic [WIDTH-1:0]   w_arm_lo;
  logic [WIDTH-1:0]   w_arm_hi;
  logic               w_arm;
  logic               w_fire;
  logic               w_is_auto;
  logic               w_is_single;
  logic               w_timeout_hit;
  logic               w_we;
  logic               w_back;
  logic [C_IDX_W-1:0] w_wr_ptr_nxt;
  logic [C_IDX_W-1:0] w_start_nxt;
  logic [C_IDX_W:0]   w_rd_sum;
  logic               w_rd_oob;
  logic [C_IDX_W-1:0] w_rd_addr;
  logic [WIDTH-1:0]   w_ram_q;

  // Arming thresholds saturate at the code range so extreme levels still arm.
  assign w_level_x = {1'b0, i_level};
  assign w_hi_sum  = w_level_x + C_HYST;
  assign w_arm_lo  = (w_level_x >= C_HYST) ? WIDTH'(w_level_x - C_HYST) : '0;
  assign w_arm_hi  = (w_hi_sum > C_MAX) ? C_MAX[WIDTH-1:0] : w_hi_sum[WIDTH-1:0];

  assign w_arm  = i_slope ? (i_sample > w_arm_hi) : (i_sample < w_arm_lo);
  assign w_fire = r_armed && (i_slope ? (i_sample <= i_level) : (i_sample >= i_level));

  assign w_is_auto     = (i_mode == AUTO);
  assign w_is_single   = (i_mode == SINGLE);
  assign w_timeout_hit = w_is_auto && (r_timeout == C_TO_LAST);

  assign w_we   = i_sample_valid && ((r_state == FILL) || (r_state == WAIT) || (r_state == POST));
  assign w_back = ~r_front;

  assign w_wr_ptr_nxt = (r_wr_ptr == C_LAST_ADDR) ? '0 : (r_wr_ptr + C_IDX_W'(1));
  assign w_start_nxt  = (r_trig_addr >= C_PRE) ? (r_trig_addr - C_PRE)
                                               : (r_trig_addr + C_BACK_OFS);

  // Columns past the frame read as zero; the RAM is addressed at 0 for them.
  assign w_rd_sum  = {1'b0, r_start} + {1'b0, i_rd_x};
  assign w_rd_oob  = ({1'b0, i_rd_x} >= C_DEPTH_X);
  assign w_rd_addr = w_rd_oob                  ? '0 :
                     (w_rd_sum >= C_DEPTH_X)   ? C_IDX_W'(w_rd_sum - C_DEPTH_X) :
                                                 C_IDX_W'(w_rd_sum);

  capture_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_we      (w_we),
    .i_wr_bank (w_back),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_sample),
    .i_rd_bank (r_front),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_zero <= 1'b1;
    end else begin
      r_rd_zero <= w_rd_oob;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= FILL;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_start      <= '0;
      r_trig_addr  <= '0;
      r_timeout    <= '0;
      r_front      <= 1'b0;
      r_armed      <= 1'b0;
      r_trig_flag  <= 1'b0;
      r_triggered  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_we) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      case (r_state)
        FILL: begin
          if (i_sample_valid) begin
            if (r_cnt == C_PRE_LAST) begin
              r_cnt     <= '0;
              r_armed   <= 1'b0;
              r_timeout <= '0;
              r_state   <= WAIT;
            end else begin
              r_cnt <= r_cnt + C_IDX_W'(1);
            end
          end
        end
        WAIT: begin
          if (i_sample_valid) begin
            if (w_arm) begin
              r_armed <= 1'b1;
            end
            // Saturate so a later switch into auto cannot wrap past the limit.
            if (r_timeout != C_TO_LAST) begin
              r_timeout <= r_timeout + C_TO_W'(1);
            end
            if (w_fire || w_timeout_hit) begin
              r_trig_addr <= r_wr_ptr;
              r_trig_flag <= w_fire;
              r_cnt       <= '0;
              r_state     <= (C_POST_N > 0) ? POST : SWAP;
            end
          end
        end
        POST: begin
          if (i_sample_valid) begin
            if (r_cnt == C_POST_LAST) begin
              r_cnt   <= '0;
              r_state <= SWAP;
            end else begin
              r_cnt <= r_cnt + C_IDX_W'(1);
            end
          end
        end
        SWAP: begin
          r_front      <= ~r_front;
          r_start      <= w_start_nxt;
          r_triggered  <= r_trig_flag;
          r_frame_done <= 1'b1;
          r_cnt        <= '0;
          r_state      <= w_is_single ? HOLD : FILL;
        end
        HOLD: begin
          if (i_rearm) begin
            r_cnt   <= '0;
            r_state <= FILL;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= FILL;
        end
      endcase
    end
  end

  assign o_rd_data    = r_rd_zero ? '0 : w_ram_q;
  assign o_state      = r_state;
  assign o_triggered  = r_triggered;
  assign o_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_trigger_capture
// Self-checking bench for trigger_capture (DEPTH=16, PRE=4, HYST=2, TO=32).
// Rev    : 1.0
// ============================================================================
module tb_trigger_capture;
  import scope_pkg::*;

  localparam int W  = 10;
  localparam int D  = 16;
  localparam int D2 = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic [W-1:0] sample;
  logic [W-1:0] level;
  logic         slope;
  logic [1:0]   mode;
  logic         rearm;
  logic [3:0]   rd_x;
  logic [W-1:0] rd_data;
  logic [2:0]   state;
  logic         triggered;
  logic         frame_done;
  logic [3:0]   rd_x2;
  logic [W-1:0] rd_data2;
  logic [2:0]   state2;
  logic         triggered2;
  logic         frame_done2;

  always #5 clk = ~clk;

  trigger_capture #(.WIDTH(W), .DEPTH(D), .PRE(4), .HYST(2), .AUTO_TIMEOUT(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(valid), .i_sample(sample),
    .i_level(level), .i_slope(slope), .i_mode(mode), .i_rearm(rearm), .i_rd_x(rd_x),
    .o_rd_data(rd_data), .o_state(state), .o_triggered(triggered), .o_frame_done(frame_done)
  );

  // Non-power-of-two depth so a column past the frame is addressable.
  trigger_capture #(.WIDTH(W), .DEPTH(D2), .PRE(4), .HYST(2), .AUTO_TIMEOUT(32)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_valid(valid), .i_sample(sample),
    .i_level(level), .i_slope(slope), .i_mode(mode), .i_rearm(rearm), .i_rd_x(rd_x2),
    .o_rd_data(rd_data2), .o_state(state2), .o_triggered(triggered2), .o_frame_done(frame_done2)
  );

  typedef struct {
    logic [3:0]   x;
    logic [W-1:0] exp;
  } rd_vec_t;

  rd_vec_t      vecs[$];
  logic [W-1:0] sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           fd_cnt = 0;
  int           ramp_ph = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    valid  = 1'b1;
    sample = v;
    tick();
    valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Expected read data is queued with the address and retired one clock later.
  task automatic run_reads(input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    foreach (vecs[i]) begin
      rd_x = vecs[i].x;
      sb.push_back(vecs[i].exp);
      @(posedge clk);
      @(negedge clk);
      got = rd_data;
      exp = sb.pop_front();
      check($sformatf("%s rd x=%0d", tag, vecs[i].x), 32'(got), 32'(exp));
    end
    vecs.delete();
    tick();
  endtask

  task automatic ramp_until_frame(input int budget, input logic falling);
    int fd0;
    fd0 = fd_cnt;
    for (int k = 0; k < budget && fd_cnt == fd0; k++) begin
      send(falling ? W'(15 - (ramp_ph % 16)) : W'(ramp_ph % 16));
      ramp_ph++;
    end
  endtask

  initial begin
    int fd0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    sample = '0;
    level  = '0;
    slope  = 1'b0;
    mode   = 2'b00;
    rearm  = 1'b0;
    rd_x   = '0;
    rd_x2  = '0;

    // Auto, rising, level 8, repeating ramp
    do_reset();
    check("reset state", 32'(state), 32'(FILL));
    check("reset rd_data", 32'(rd_data), 0);
    check("reset triggered", 32'(triggered), 0);
    check("reset frame_done", 32'(frame_done), 0);
    level = 10'd8;
    fd0 = fd_cnt;
    for (int k = 0; k < 24; k++) send(W'(k % 16));
    check("ramp frame count", 32'(fd_cnt - fd0), 1);
    check("ramp triggered", 32'(triggered), 1);
    vecs.push_back('{x: 4'd0,  exp: 10'd4});
    vecs.push_back('{x: 4'd4,  exp: 10'd8});
    vecs.push_back('{x: 4'd11, exp: 10'd15});
    vecs.push_back('{x: 4'd15, exp: 10'd3});
    run_reads("ramp");

    // Auto, constant below level: forced frame exactly at the timeout
    do_reset();
    level = 10'd500;
    fd0 = fd_cnt;
    for (int k = 0; k < 46; k++) send(10'd100);
    check("timeout early frame", 32'(fd_cnt - fd0), 0);
    send(10'd100);
    check("timeout frame count", 32'(fd_cnt - fd0), 1);
    check("timeout triggered", 32'(triggered), 0);
    for (int x = 0; x < D; x++) vecs.push_back('{x: 4'(x), exp: 10'd100});
    run_reads("timeout");
    rd_x2 = 4'd13;
    @(posedge clk);
    @(negedge clk);
    check("oob column", 32'(rd_data2), 0);
    rd_x2 = 4'd11;
    @(posedge clk);
    @(negedge clk);
    check("last column", 32'(rd_data2), 100);
    tick();

    // Normal mode never forces a frame; mode 3 behaves as normal
    do_reset();
    mode = 2'b01;
    fd0 = fd_cnt;
    for (int k = 0; k < 200; k++) send(10'd100);
    check("normal no frame", 32'(fd_cnt - fd0), 0);
    check("normal state", 32'(state), 32'(WAIT));
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    tick();
    check("rearm ignored", 32'(state), 32'(WAIT));
    mode = 2'b11;
    for (int k = 0; k < 40; k++) send(10'd100);
    check("mode3 no frame", 32'(fd_cnt - fd0), 0);

    // Single, falling, level 8
    do_reset();
    mode    = 2'b10;
    slope   = 1'b1;
    level   = 10'd8;
    ramp_ph = 0;
    fd0 = fd_cnt;
    ramp_until_frame(40, 1'b1);
    check("single frame", 32'(fd_cnt - fd0), 1);
    check("single hold", 32'(state), 32'(HOLD));
    check("single triggered", 32'(triggered), 1);
    vecs.push_back('{x: 4'd4, exp: 10'd8});
    vecs.push_back('{x: 4'd0, exp: 10'd12});
    run_reads("single");
    for (int k = 0; k < 32; k++) begin
      send(W'(15 - (ramp_ph % 16)));
      ramp_ph++;
    end
    check("hold no frame", 32'(fd_cnt - fd0), 1);
    check("hold state", 32'(state), 32'(HOLD));
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    check("rearm to fill", 32'(state), 32'(FILL));
    ramp_until_frame(40, 1'b1);
    check("rearm frame", 32'(fd_cnt - fd0), 2);
    check("rearm hold", 32'(state), 32'(HOLD));
    vecs.push_back('{x: 4'd4, exp: 10'd8});
    run_reads("rearm");

    // Reset mid-POST aborts the frame and returns front to bank 0
    do_reset();
    mode    = 2'b00;
    slope   = 1'b0;
    level   = 10'd8;
    ramp_ph = 0;
    fd0 = fd_cnt;
    ramp_until_frame(40, 1'b0);
    check("pre-abort frame", 32'(fd_cnt - fd0), 1);
    check("pre-abort front", 32'(u_dut.r_front), 1);
    for (int k = 0; k < 40 && state != POST; k++) begin
      send(W'(ramp_ph % 16));
      ramp_ph++;
    end
    send(W'(ramp_ph % 16));
    ramp_ph++;
    check("abort in post", 32'(state), 32'(POST));
    rst_n = 1'b0;
    #1;
    check("abort state", 32'(state), 32'(FILL));
    check("abort front", 32'(u_dut.r_front), 0);
    tick();
    tick();
    check("abort frame_done", 32'(fd_cnt - fd0), 1);
    rst_n = 1'b1;
    tick();
    ramp_until_frame(40, 1'b0);
    check("post-abort frame", 32'(fd_cnt - fd0), 2);
    check("post-abort triggered", 32'(triggered), 1);
    vecs.push_back('{x: 4'd4, exp: 10'd8});
    run_reads("post-abort");

    // Write pointer wraps: trigger lands at address 1, start becomes 13
    do_reset();
    mode  = 2'b01;
    level = 10'd8;
    fd0 = fd_cnt;
    for (int k = 0; k < 4; k++) send(10'd0);
    for (int k = 1; k <= 13; k++) send(W'(k % 6));
    send(10'd8);
    for (int i = 0; i < 11; i++) send(W'(20 + i));
    check("wrap frame", 32'(fd_cnt - fd0), 1);
    check("wrap start", 32'(u_dut.r_start), 13);
    vecs.push_back('{x: 4'd0,  exp: 10'd4});
    vecs.push_back('{x: 4'd3,  exp: 10'd1});
    vecs.push_back('{x: 4'd4,  exp: 10'd8});
    vecs.push_back('{x: 4'd5,  exp: 10'd20});
    vecs.push_back('{x: 4'd14, exp: 10'd29});
    vecs.push_back('{x: 4'd15, exp: 10'd30});
    run_reads("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
